// File: rtl/rx_pkg.sv
// Shared definitions for the UART receive write controller: state
// encoding and default widths.
`timescale 1ns/1ps
package rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_FULL = 2'd2
   } rx_state_e;

   localparam int RX_ADDR_W = 15;
   localparam int RX_DATA_W = 8;

endpackage : rx_pkg

// File: rtl/rx_edge_det.sv
// 1-bit registered rising-edge detector. The delay flop updates every
// cycle, so a level that is already high never produces a second rise.
`timescale 1ns/1ps
module rx_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_i,
   output logic sig_q_o,
   output logic rise_o
);

   logic sig_d;
   logic sig_q;

   // next value of the delay flop is simply the current input
   always_comb begin
      sig_d = sig_i;
   end

   // one-cycle delay of the input, cleared by async reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig_q_o = sig_q;
   assign rise_o  = sig_i & ~sig_q;

endmodule : rx_edge_det

// File: rtl/rx_wr_ctrl.sv
// UART receive write controller. Each rising edge of rx_dv becomes one
// registered RAM write at a pointer that wraps at DEPTH-1. Tracks fill
// count, full, sticky overflow and an active-low full LED.
// Handshake: rx_dv has no ready; an accept is rx_dv high while it was low
// the cycle before. The write strobe follows the accepting edge by one
// registered cycle; the RAM is assumed to always take the write.
`timescale 1ns/1ps
module rx_wr_ctrl
   import rx_pkg::*;
#(
   parameter int ADDR_W = RX_ADDR_W,
   parameter int DEPTH  = 2**ADDR_W,
   parameter int DATA_W = RX_DATA_W,
   parameter bit WRAP   = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_rx,
   input  logic              rx_dv,
   input  logic [DATA_W-1:0] rx_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              overflow,
   output logic              outled_rx
);

   if (DEPTH < 1 || DEPTH > (2**ADDR_W)) begin : g_depth_chk
      $error("rx_wr_ctrl: DEPTH must lie in 1..2**ADDR_W");
   end

   // Last legal pointer value and the saturated count value.
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);

   logic accept;
   logic rx_dv_q;

   rx_edge_det u_edge (
      .clk     (clk),
      .rst_n   (rst_n),
      .sig_i   (rx_dv),
      .sig_q_o (rx_dv_q),
      .rise_o  (accept)
   );

   rx_state_e         state_d,    state_q;
   logic [ADDR_W-1:0] ptr_d,      ptr_q;
   logic [ADDR_W:0]   count_d,    count_q;
   logic              full_d,     full_q;
   logic              overflow_d, overflow_q;
   logic              led_d,      led_q;
   logic              we_d,       we_q;
   logic [ADDR_W-1:0] addr_d,     addr_q;
   logic [DATA_W-1:0] wdata_d,    wdata_q;

   logic [ADDR_W-1:0] ptr_next;
   logic [ADDR_W:0]   count_inc;

   // pointer wraps at DEPTH-1, never at the natural 2**ADDR_W boundary
   always_comb begin
      ptr_next  = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      count_inc = count_q + 1'b1;
   end

   // next state and next registered outputs; a low enable beats any accept
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      count_d    = count_q;
      full_d     = full_q;
      overflow_d = overflow_q;
      led_d      = led_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;

      if (!en_rx) begin
         state_d    = ST_IDLE;
         ptr_d      = '0;
         count_d    = '0;
         full_d     = 1'b0;
         overflow_d = 1'b0;
         led_d      = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_RECV;
            end
            ST_RECV: begin
               if (accept) begin
                  we_d    = 1'b1;
                  addr_d  = ptr_q;
                  wdata_d = rx_data;
                  ptr_d   = ptr_next;
                  count_d = count_inc;
                  if (count_inc == CNT_FULL) begin
                     state_d = ST_FULL;
                     full_d  = 1'b1;
                     led_d   = 1'b0;
                  end
               end
            end
            ST_FULL: begin
               if (accept) begin
                  overflow_d = 1'b1;
                  if (WRAP) begin
                     we_d    = 1'b1;
                     addr_d  = ptr_q;
                     wdata_d = rx_data;
                     ptr_d   = ptr_next;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // single state/output register bank; reset aborts any pending write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         led_q      <= 1'b1;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
         led_q      <= led_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign count     = count_q;
   assign full      = full_q;
   assign overflow  = overflow_q;
   assign outled_rx = led_q;

endmodule : rx_wr_ctrl

// File: tb/tb_rx_wr_ctrl.sv
// Directed bench for rx_wr_ctrl. Three instances share one stimulus:
// a: ADDR_W=3 DEPTH=5 WRAP=0, b: same sizes WRAP=1, c: default sizes.
`timescale 1ns/1ps
module tb_rx_wr_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en_rx;
   logic       rx_dv;
   logic [7:0] rx_data;

   logic       a_we, a_full, a_ovf, a_led;
   logic [2:0] a_addr;
   logic [7:0] a_wdata;
   logic [3:0] a_count;

   logic       b_we, b_full, b_ovf, b_led;
   logic [2:0] b_addr;
   logic [7:0] b_wdata;
   logic [3:0] b_count;

   logic        c_we, c_full, c_ovf, c_led;
   logic [14:0] c_addr;
   logic [7:0]  c_wdata;
   logic [15:0] c_count;

   int n_checks = 0;
   int n_fail   = 0;

   rx_wr_ctrl #(.ADDR_W(3), .DEPTH(5), .DATA_W(8), .WRAP(1'b0)) u_a (
      .clk(clk), .rst_n(rst_n), .en_rx(en_rx), .rx_dv(rx_dv), .rx_data(rx_data),
      .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata), .count(a_count),
      .full(a_full), .overflow(a_ovf), .outled_rx(a_led)
   );

   rx_wr_ctrl #(.ADDR_W(3), .DEPTH(5), .DATA_W(8), .WRAP(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n), .en_rx(en_rx), .rx_dv(rx_dv), .rx_data(rx_data),
      .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .count(b_count),
      .full(b_full), .overflow(b_ovf), .outled_rx(b_led)
   );

   rx_wr_ctrl u_c (
      .clk(clk), .rst_n(rst_n), .en_rx(en_rx), .rx_dv(rx_dv), .rx_data(rx_data),
      .mem_we(c_we), .mem_addr(c_addr), .mem_wdata(c_wdata), .count(c_count),
      .full(c_full), .overflow(c_ovf), .outled_rx(c_led)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d fails=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // one-cycle rx_dv pulse; returns at the negedge after the accepting edge
   task automatic pulse(input logic [7:0] d);
      @(negedge clk);
      rx_dv   = 1'b1;
      rx_data = d;
      @(negedge clk);
      rx_dv   = 1'b0;
   endtask

   initial begin
      int         nwe;
      logic [2:0] seen_addr;
      logic [7:0] seen_data;

      // reset with enable high and rx_dv already high
      rst_n   = 1'b0;
      en_rx   = 1'b1;
      rx_dv   = 1'b1;
      rx_data = 8'h00;
      #22;
      check("rst_we",    32'(a_we), 32'd0);
      check("rst_addr",  32'(a_addr), 32'd0);
      check("rst_wdata", 32'(a_wdata), 32'd0);
      check("rst_count", 32'(a_count), 32'd0);
      check("rst_full",  32'(a_full), 32'd0);
      check("rst_ovf",   32'(a_ovf), 32'd0);
      check("rst_led",   32'(a_led), 32'd1);
      check("rst_c_count", 32'(c_count), 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      nwe = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (a_we) nwe++;
      end
      check("held_level_no_write", 32'(nwe), 32'd0);
      check("held_level_count", 32'(a_count), 32'd0);
      rx_dv = 1'b0;

      // five writes fill a (DEPTH=5)
      for (int i = 0; i < 5; i++) begin
         pulse(8'hA1 + 8'(i));
         check("fill_we",    32'(a_we), 32'd1);
         check("fill_addr",  32'(a_addr), 32'(i));
         check("fill_wdata", 32'(a_wdata), 32'hA1 + 32'(i));
         check("fill_count", 32'(a_count), 32'(i + 1));
         check("ring_addr",  32'(b_addr), 32'(i));
      end
      check("full_flag",  32'(a_full), 32'd1);
      check("full_led",   32'(a_led), 32'd0);
      check("full_ovf",   32'(a_ovf), 32'd0);
      check("ring_ovf_before", 32'(b_ovf), 32'd0);
      @(negedge clk);
      check("gap_we", 32'(a_we), 32'd0);

      // sixth: dropped in a, wraps in b
      pulse(8'hA6);
      check("drop_we",    32'(a_we), 32'd0);
      check("drop_ovf",   32'(a_ovf), 32'd1);
      check("drop_count", 32'(a_count), 32'd5);
      check("ring6_we",   32'(b_we), 32'd1);
      check("ring6_addr", 32'(b_addr), 32'd0);
      check("ring6_data", 32'(b_wdata), 32'hA6);
      check("ring6_ovf",  32'(b_ovf), 32'd1);
      check("ring6_count", 32'(b_count), 32'd5);

      // seventh
      pulse(8'hA7);
      check("drop7_we",   32'(a_we), 32'd0);
      check("ring7_addr", 32'(b_addr), 32'd1);
      check("ring7_we",   32'(b_we), 32'd1);
      check("ring7_count", 32'(b_count), 32'd5);

      // async reset while b's write strobe is high
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_we",    32'(b_we), 32'd0);
      check("arst_led",   32'(a_led), 32'd1);
      check("arst_full",  32'(a_full), 32'd0);
      check("arst_count", 32'(a_count), 32'd0);
      check("arst_ovf",   32'(a_ovf), 32'd0);
      check("arst_addr",  32'(b_addr), 32'd0);
      @(negedge clk);
      rx_dv = 1'b0;
      en_rx = 1'b1;
      rst_n = 1'b1;

      // clear collision
      pulse(8'h11);
      check("pre_clr_addr",  32'(a_addr), 32'd0);
      check("pre_clr_count", 32'(a_count), 32'd1);
      @(negedge clk);
      en_rx   = 1'b0;
      rx_dv   = 1'b1;
      rx_data = 8'h55;
      @(negedge clk);
      check("clr_we",    32'(a_we), 32'd0);
      check("clr_count", 32'(a_count), 32'd0);
      rx_dv = 1'b0;
      en_rx = 1'b1;
      pulse(8'h22);
      check("reen_we",    32'(a_we), 32'd1);
      check("reen_addr",  32'(a_addr), 32'd0);
      check("reen_wdata", 32'(a_wdata), 32'h22);
      check("reen_count", 32'(a_count), 32'd1);

      // long level: exactly one write
      @(negedge clk);
      rx_dv     = 1'b1;
      rx_data   = 8'h3C;
      nwe       = 0;
      seen_addr = 3'd7;
      seen_data = 8'h00;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (a_we) begin
            nwe++;
            seen_addr = a_addr;
            seen_data = a_wdata;
         end
      end
      rx_dv = 1'b0;
      check("level_nwe",   32'(nwe), 32'd1);
      check("level_addr",  32'(seen_addr), 32'd1);
      check("level_data",  32'(seen_data), 32'h3C);
      check("level_count", 32'(a_count), 32'd2);

      // full default depth
      @(negedge clk);
      en_rx = 1'b0;
      @(negedge clk);
      en_rx = 1'b1;
      check("big_clr_count", 32'(c_count), 32'd0);
      for (int i = 0; i < 32768; i++) begin
         pulse(8'(i));
         if (i == 0) begin
            check("big_first_addr", 32'(c_addr), 32'd0);
         end
         if (i == 32766) begin
            check("big_almost_count", 32'(c_count), 32'h7FFF);
            check("big_almost_full",  32'(c_full), 32'd0);
         end
      end
      check("big_last_we",    32'(c_we), 32'd1);
      check("big_last_addr",  32'(c_addr), 32'h7FFF);
      check("big_last_data",  32'(c_wdata), 32'hFF);
      check("big_full",       32'(c_full), 32'd1);
      check("big_led",        32'(c_led), 32'd0);
      check("big_count",      32'(c_count), 32'h8000);
      pulse(8'h5A);
      check("big_drop_we",  32'(c_we), 32'd0);
      check("big_drop_ovf", 32'(c_ovf), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_rx_wr_ctrl

// File: doc/rx_wr_ctrl.md
# rx_wr_ctrl

Parametrised UART receive write controller, successor to the single-counter RX address generator. It sits between the UART receiver (byte + data-valid strobe) and the receive buffer RAM. It turns each received byte into exactly one synchronous RAM write at an incrementing address. It also reports fill count, full, overflow and an active-low status LED. All logic is synchronous to `clk`; nothing is clocked by `rx_dv`.

## Interface
- `ADDR_W`, 15, RAM address width.
- `DEPTH`, 2**ADDR_W, buffer capacity in bytes; legal range 1..2**ADDR_W.
- `DATA_W`, 8, received word width.
- `WRAP`, 0, 0 = stop when full, 1 = ring mode (keep writing, wrap address).
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en_rx` in 1: receive enable; low = synchronous clear and idle.
- `rx_dv` in 1: data-valid from UART RX, synchronous to `clk`, pulse or level of any length.
- `rx_data` in DATA_W: byte qualified by `rx_dv`.
- `mem_we` out 1: one-cycle RAM write strobe.
- `mem_addr` out ADDR_W: RAM write address.
- `mem_wdata` out DATA_W: RAM write data.
- `count` out ADDR_W+1: bytes held, saturates at DEPTH.
- `full` out 1: count == DEPTH.
- `overflow` out 1: sticky, a byte was dropped (WRAP=0) or overwritten (WRAP=1).
- `outled_rx` out 1: active-low status, 0 while `full`, else 1.

## Operation
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `count`=0, `full`=0, `overflow`=0, `outled_rx`=1, state IDLE, edge register 0.
- Accept event is a rising edge of `rx_dv`: `rx_dv & ~rx_dv_q`. `rx_dv_q` updates every cycle in every state. A level already high when `en_rx` rises is not counted. A level held high counts once.
- States:
  - IDLE: `en_rx`=0. Pointer, `count`, `full` and `overflow` are cleared synchronously. `outled_rx`=1. Accepts are ignored. Goes to RECV when `en_rx`=1.
  - RECV: on accept, write at the pointer, then pointer+1. `count`+1. Goes to FULL when `count` reaches DEPTH.
  - FULL:
    - WRAP=0: accepts are dropped, no `mem_we`, `overflow` set.
    - WRAP=1: accepts are still written, `count` stays DEPTH, `overflow` set on the first write in FULL.
- Pointer wraps from DEPTH-1 to 0. `mem_addr` never reaches DEPTH. It is not a free-running ADDR_W counter.
- `en_rx`=0 in any state goes to IDLE on the next edge.
- The same-cycle clear wins: if an accept and `en_rx`=0 arrive together, the byte is dropped and no write occurs.
- Asynchronous reset mid-write aborts the write; `mem_we` drops immediately.

## Timing
- Accept sampled at edge N: `mem_we`=1, `mem_addr`=old pointer, `mem_wdata`=`rx_data` captured at edge N, all during cycle N→N+1.
- `count`, `full` and `outled_rx` update at the same edge N, registered.
- Write latency is 1 cycle. Back-to-back accepts need `rx_dv` low for at least one cycle between them, so throughput is one byte per 2 cycles.
- `overflow` is set at the edge of the dropped or overwriting accept. It clears only on IDLE or reset.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `rx_pkg`:
  - state encoding constants `ST_IDLE`, `ST_RECV`, `ST_FULL`;
  - default `RX_ADDR_W`=15 and `RX_DATA_W`=8.
- Sub-module `rx_edge_det`: 1-bit registered rising-edge detector with async active-low reset. The block has no other sub-modules.
- Elaboration check: error if DEPTH > 2**ADDR_W or DEPTH < 1.

## Test plan
- Reset and enable:
  - Assert `rst_n`=0 mid-stream → all outputs return to reset values at once, `outled_rx`=1.
  - Release with `en_rx`=1 and `rx_dv` high → no write until `rx_dv` falls and rises again.
- Basic write, ADDR_W=3, DEPTH=5, WRAP=0:
  - Five 1-cycle pulses with data 0xA1..0xA5 → writes at addresses 0..4 with matching data, 1-cycle latency each.
  - `count`=5, `full`=1, `outled_rx`=0.
  - Sixth pulse → no `mem_we`, `overflow`=1, `count` stays 5.
- Ring mode, same parameters, WRAP=1:
  - Seven pulses → addresses 0,1,2,3,4,0,1.
  - `count` saturates at 5.
  - `overflow` rises on the 6th write.
- Long level: `rx_dv` held high for 10 cycles with data 0x3C → exactly one write of 0x3C. `count` increments by 1.
- Clear collision: `en_rx`=0 in the same cycle as a `rx_dv` rising edge → no `mem_we`, `count`=0. Next accept after re-enable writes at address 0.
- Full default depth, ADDR_W=15: 32768 pulses → last write at address 0x7FFF, `full`=1, `outled_rx`=0, `count`=0x8000.
